// File: rtl/hovalaag_feed_sequencer.sv
// Feed sequencer for the hovalaag core's 12-bit pin bus: each frame is three
// instruction beats followed by optional IN1/IN2 data beats, with wait-state timeout.
module hovalaag_feed_sequencer #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [1:0]  instr_need,
  input  logic        in1_valid,
  output logic        in1_ready,
  input  logic [11:0] in1_data,
  input  logic        in2_valid,
  output logic        in2_ready,
  input  logic [11:0] in2_data,
  output logic        bus_valid,
  output logic [11:0] bus_data,
  output logic [1:0]  bus_tag,
  output logic [1:0]  bus_beat,
  output logic        busy,
  output logic        timeout_err,
  output logic [15:0] stall_count,
  output logic [15:0] frame_count
);

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] TAG_IDLE  = 2'b00;
  localparam logic [1:0] TAG_INSTR = 2'b01;
  localparam logic [1:0] TAG_IN1   = 2'b10;
  localparam logic [1:0] TAG_IN2   = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_I0, S_I1, S_I2, S_W1, S_W2} state_e;

  state_e          state_q;
  logic [31:0]     instr_q;
  logic [1:0]      need_q;
  logic [WW-1:0]   wait_q;
  logic            bus_valid_q;
  logic [11:0]     bus_data_q;
  logic [1:0]      bus_tag_q;
  logic [1:0]      bus_beat_q;
  logic            timeout_err_q;
  logic [15:0]     stall_q;
  logic [15:0]     frame_q;

  logic            in_wait;
  logic            cur_valid;
  logic [11:0]     cur_data;
  logic            tmo_hit;
  logic            xfer;
  logic            tmo_take;

  assign in_wait   = (state_q == S_W1) || (state_q == S_W2);
  assign cur_valid = (state_q == S_W1) ? in1_valid : in2_valid;
  assign cur_data  = (state_q == S_W1) ? in1_data : in2_data;
  assign tmo_hit   = (TIMEOUT != 0) && (wait_q == WW'(TIMEOUT - 1));
  assign xfer      = in_wait && cur_valid;
  assign tmo_take  = in_wait && !cur_valid && tmo_hit;

  // Ready is withdrawn only on the timeout cycle with no data pending, so a
  // source that shows up exactly on that cycle still gets its word through.
  assign instr_ready = (state_q == S_IDLE) && !halt;
  assign in1_ready   = (state_q == S_W1) && (in1_valid || !tmo_hit);
  assign in2_ready   = (state_q == S_W2) && (in2_valid || !tmo_hit);

  assign bus_valid   = bus_valid_q;
  assign bus_data    = bus_data_q;
  assign bus_tag     = bus_tag_q;
  assign bus_beat    = bus_beat_q;
  assign busy        = (state_q != S_IDLE);
  assign timeout_err = timeout_err_q;
  assign stall_count = stall_q;
  assign frame_count = frame_q;

  // NOTE: all state, including the latched instruction and need bits, is reset
  // so a frame abandoned by reset cannot leak a stale beat afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      need_q        <= '0;
      wait_q        <= '0;
      bus_valid_q   <= 1'b0;
      bus_data_q    <= '0;
      bus_tag_q     <= TAG_IDLE;
      bus_beat_q    <= '0;
      timeout_err_q <= 1'b0;
      stall_q       <= '0;
      frame_q       <= '0;
    end else begin
      // NOTE: non-blocking throughout; these defaults are overridden below only
      // on cycles that emit a beat, while bus_data deliberately holds.
      bus_valid_q <= 1'b0;
      bus_tag_q   <= TAG_IDLE;
      bus_beat_q  <= 2'd0;
      unique case (state_q)
        S_IDLE: begin
          if (instr_valid && instr_ready) begin
            instr_q     <= instr;
            need_q      <= instr_need;
            bus_valid_q <= 1'b1;
            bus_data_q  <= instr[11:0];
            bus_tag_q   <= TAG_INSTR;
            bus_beat_q  <= 2'd0;
            state_q     <= S_I0;
          end
        end
        S_I0: begin
          bus_valid_q <= 1'b1;
          bus_data_q  <= instr_q[23:12];
          bus_tag_q   <= TAG_INSTR;
          bus_beat_q  <= 2'd1;
          state_q     <= S_I1;
        end
        S_I1: begin
          bus_valid_q <= 1'b1;
          bus_data_q  <= {4'b0, instr_q[31:24]};
          bus_tag_q   <= TAG_INSTR;
          bus_beat_q  <= 2'd2;
          state_q     <= S_I2;
        end
        S_I2: begin
          if (need_q[0]) begin
            state_q <= S_W1;
          end else if (need_q[1]) begin
            state_q <= S_W2;
          end else begin
            state_q <= S_IDLE;
            frame_q <= frame_q + 16'd1;
          end
        end
        S_W1, S_W2: begin
          if (xfer || tmo_take) begin
            bus_valid_q <= 1'b1;
            bus_data_q  <= xfer ? cur_data : 12'h000;
            bus_tag_q   <= (state_q == S_W1) ? TAG_IN1 : TAG_IN2;
            bus_beat_q  <= 2'd0;
            wait_q      <= '0;
            if (tmo_take) begin
              timeout_err_q <= 1'b1;
            end
            if ((state_q == S_W1) && need_q[1]) begin
              state_q <= S_W2;
            end else begin
              state_q <= S_IDLE;
              frame_q <= frame_q + 16'd1;
            end
          end else begin
            wait_q <= wait_q + 1'b1;
            if (stall_q != 16'hFFFF) begin
              stall_q <= stall_q + 16'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hovalaag_feed_sequencer.sv
// Bench for hovalaag_feed_sequencer: a frame-level model plans a cycle-by-cycle
// stimulus/expectation timeline, which is then replayed and compared.
module tb_hovalaag_feed_sequencer;

  localparam int T    = 8;
  localparam int NF   = 50;
  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [1:0]  instr_need;
  logic        in1_valid, in2_valid;
  logic        in1_ready, in2_ready;
  logic [11:0] in1_data, in2_data;
  logic        bus_valid;
  logic [11:0] bus_data;
  logic [1:0]  bus_tag;
  logic [1:0]  bus_beat;
  logic        busy;
  logic        timeout_err;
  logic [15:0] stall_count;
  logic [15:0] frame_count;

  hovalaag_feed_sequencer #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_need(instr_need),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data),
    .in2_valid(in2_valid), .in2_ready(in2_ready), .in2_data(in2_data),
    .bus_valid(bus_valid), .bus_data(bus_data), .bus_tag(bus_tag), .bus_beat(bus_beat),
    .busy(busy), .timeout_err(timeout_err),
    .stall_count(stall_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Stimulus timeline
  bit          s_ivalid [MAXC];
  logic [31:0] s_instr  [MAXC];
  logic [1:0]  s_need   [MAXC];
  bit          s_halt   [MAXC];
  bit          s_v      [2][MAXC];
  logic [11:0] s_d      [2][MAXC];
  // Expectation timeline
  bit          e_bv     [MAXC];
  logic [11:0] e_bd     [MAXC];
  logic [1:0]  e_tag    [MAXC];
  logic [1:0]  e_beat   [MAXC];
  bit          e_busy   [MAXC];
  bit          e_rdy    [2][MAXC];
  bit          e_fdone  [MAXC];
  int          e_stall  [MAXC];
  bit          e_err    [MAXC];

  task automatic put_beat(input int c, input logic [1:0] tag, input logic [11:0] d,
                          input logic [1:0] beat);
    e_bv[c] = 1'b1; e_tag[c] = tag; e_bd[c] = d; e_beat[c] = beat;
  endtask

  int nc;

  initial begin
    int t_prev, fe_prev, cum_stall, fc;
    bit cum_err;

    for (int c = 0; c < MAXC; c++) begin
      s_ivalid[c] = 0; s_instr[c] = $urandom; s_need[c] = 2'($urandom); s_halt[c] = 0;
      e_bv[c] = 0; e_bd[c] = '0; e_tag[c] = 2'b00; e_beat[c] = 2'd0; e_busy[c] = 0;
      e_fdone[c] = 0; e_stall[c] = 0; e_err[c] = 0;
      for (int k = 0; k < 2; k++) begin
        s_v[k][c] = 0; s_d[k][c] = 12'($urandom); e_rdy[k][c] = 0;
      end
    end

    // Frame-level planning: the need bits, source delays and halt windows fix
    // when each beat must appear and how many wait cycles accrue.
    t_prev = 1; fe_prev = 2; cum_stall = 0; cum_err = 0;
    for (int f = 0; f < NF; f++) begin
      logic [31:0] iw;
      logic [1:0]  nd;
      logic [11:0] dv;
      int vs, hf, acc, e;
      int dd [2];
      bit use_halt;
      iw = $urandom;
      nd = 2'($urandom_range(0, 3));
      vs = fe_prev + $urandom_range(0, 4) - 2;
      if (vs < t_prev + 1) vs = t_prev + 1;
      use_halt = (f > 0) && ($urandom_range(0, 3) == 0);
      hf = fe_prev + $urandom_range(0, 4);
      dd[0] = $urandom_range(0, T + 1);
      dd[1] = $urandom_range(0, T + 1);
      case (f)
        0: begin iw = 32'hABCDE123; nd = 2'b00; use_halt = 0; vs = 2; end
        1: begin nd = 2'b11; dd[0] = 0; dd[1] = 3; use_halt = 0; end
        2: begin nd = 2'b01; dd[0] = T + 1; use_halt = 0; end
        3, 4, 5: begin nd = 2'b00; vs = t_prev + 1; use_halt = 0; end
        6: begin nd = 2'b00; vs = t_prev + 1; use_halt = 1; hf = fe_prev + 3; end
        default: ;
      endcase
      if (use_halt)
        for (int c = t_prev + 2; c < hf; c++) s_halt[c] = 1;
      acc = vs;
      if (acc < fe_prev) acc = fe_prev;
      if (use_halt && acc < hf) acc = hf;
      for (int c = vs; c <= acc; c++) begin
        s_ivalid[c] = 1; s_instr[c] = iw; s_need[c] = nd;
      end
      put_beat(acc + 1, 2'b01, iw[11:0], 2'd0);
      put_beat(acc + 2, 2'b01, iw[23:12], 2'd1);
      put_beat(acc + 3, 2'b01, {4'b0, iw[31:24]}, 2'd2);
      e = acc + 4;
      for (int k = 0; k < 2; k++) begin
        if (nd[k]) begin
          if (dd[k] <= T - 1) begin
            for (int c = e; c <= e + dd[k]; c++) e_rdy[k][c] = 1;
            dv = 12'($urandom);
            s_v[k][e + dd[k]] = 1;
            s_d[k][e + dd[k]] = dv;
            put_beat(e + dd[k] + 1, (k == 0) ? 2'b10 : 2'b11, dv, 2'd0);
            cum_stall += dd[k];
            e = e + dd[k] + 1;
          end else begin
            for (int c = e; c <= e + T - 2; c++) e_rdy[k][c] = 1;
            put_beat(e + T, (k == 0) ? 2'b10 : 2'b11, 12'h000, 2'd0);
            cum_stall += T - 1;
            cum_err = 1;
            e = e + T;
          end
        end
      end
      for (int c = acc + 1; c < e; c++) e_busy[c] = 1;
      e_fdone[e] = 1; e_stall[e] = cum_stall; e_err[e] = cum_err;
      t_prev = acc; fe_prev = e;
    end
    nc = fe_prev + 6;

    // Reset state
    rst_n = 1'b0; halt = 0; instr_valid = 0; instr = '0; instr_need = '0;
    in1_valid = 0; in2_valid = 0; in1_data = '0; in2_data = '0;
    repeat (2) @(negedge clk);
    check("reset bus_valid", bus_valid, 0);
    check("reset bus_tag", bus_tag, 0);
    check("reset bus_data", bus_data, 0);
    check("reset busy", busy, 0);
    check("reset frame_count", frame_count, 0);
    check("reset stall_count", stall_count, 0);
    check("reset timeout_err", timeout_err, 0);
    rst_n = 1'b1;

    // Replay the planned timeline cycle by cycle
    fc = 0;
    for (int c = 0; c < nc; c++) begin
      @(posedge clk); #1;
      instr_valid = s_ivalid[c]; instr = s_instr[c]; instr_need = s_need[c]; halt = s_halt[c];
      in1_valid = s_v[0][c]; in1_data = s_d[0][c];
      in2_valid = s_v[1][c]; in2_data = s_d[1][c];
      @(negedge clk);
      if (e_fdone[c]) fc++;
      check($sformatf("c%0d bus_valid", c), bus_valid, e_bv[c]);
      check($sformatf("c%0d bus_tag", c), bus_tag, e_tag[c]);
      if (e_bv[c]) begin
        check($sformatf("c%0d bus_data", c), bus_data, e_bd[c]);
        check($sformatf("c%0d bus_beat", c), bus_beat, e_beat[c]);
      end
      check($sformatf("c%0d busy", c), busy, e_busy[c]);
      check($sformatf("c%0d instr_ready", c), instr_ready, !e_busy[c] && !s_halt[c]);
      check($sformatf("c%0d in1_ready", c), in1_ready, e_rdy[0][c]);
      check($sformatf("c%0d in2_ready", c), in2_ready, e_rdy[1][c]);
      check($sformatf("c%0d frame_count", c), frame_count, fc[15:0]);
      if (e_fdone[c]) begin
        check($sformatf("c%0d stall_count", c), stall_count, e_stall[c]);
        check($sformatf("c%0d timeout_err", c), timeout_err, e_err[c]);
      end
    end

    // Reset while waiting in W1 for an IN1 word that never comes
    @(posedge clk); #1;
    instr_valid = 1; instr = 32'h12345678; instr_need = 2'b01; halt = 0;
    in1_valid = 0; in2_valid = 0;
    @(posedge clk); #1;
    instr_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("w1 in1_ready", in1_ready, 1);
    check("w1 busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid rst bus_valid", bus_valid, 0);
    check("mid rst bus_tag", bus_tag, 0);
    check("mid rst bus_data", bus_data, 0);
    check("mid rst busy", busy, 0);
    check("mid rst in1_ready", in1_ready, 0);
    check("mid rst stall_count", stall_count, 0);
    check("mid rst frame_count", frame_count, 0);
    check("mid rst timeout_err", timeout_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2 * T; i++) begin
      @(negedge clk);
      check($sformatf("post rst %0d bus_valid", i), bus_valid, 0);
      check($sformatf("post rst %0d busy", i), busy, 0);
    end
    check("post rst stall_count", stall_count, 0);
    check("post rst frame_count", frame_count, 0);
    check("post rst timeout_err", timeout_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hovalaag_feed_sequencer.md
Name: hovalaag_feed_sequencer

Overview:
- Sequences the hovalaag core's narrow 12-bit pin input bus.
- Each execution step is one frame: a 32-bit instruction from the program requester, sent as three beats, followed by zero to two 12-bit data beats from the IN1 and IN2 requester queues.
- The data beats are selected by predecoded need bits, in fixed order IN1 then IN2.
- Sits between the program/data sources and the core pins. Provides halt, timeout, stall and frame statistics.

Parameters:
- TIMEOUT, 256, wait-state cycles allowed for a data source before a zero beat is substituted; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- halt  in  1  when high, no new instruction is accepted; the current frame completes
- instr_valid  in  1  instruction offered
- instr_ready  out  1  instruction accepted when valid&&ready
- instr  in  32  instruction word
- instr_need  in  2  bit0 = frame needs IN1 beat, bit1 = frame needs IN2 beat
- in1_valid, in2_valid  in  1 each  data offered
- in1_ready, in2_ready  out  1 each  data accepted when valid&&ready
- in1_data, in2_data  in  12 each  data words
- bus_valid  out  1  beat present on bus this cycle
- bus_data  out  12  beat payload
- bus_tag  out  2  01 = instruction beat, 10 = IN1, 11 = IN2, 00 = idle
- bus_beat  out  2  instruction beat index 0..2; 0 for data beats
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky; set on any substituted beat
- stall_count  out  16  saturating count of wait cycles
- frame_count  out  16  wrapping count of completed frames

Behaviour:
- Reset (async, rst_n low):
  - state IDLE.
  - All bus outputs, counters and timeout_err are 0.
  - Wait counter and latched instr/need are cleared.
- Reset mid-frame abandons the frame. No partial beats follow the deassertion.
- Bus outputs (bus_valid, bus_data, bus_tag, bus_beat) are registered. The ready signals are combinational from state.
- States: IDLE, I0, I1, I2, W1, W2.
- IDLE:
  - instr_ready = !halt.
  - On transfer at cycle t: latch instr and need, and go to I0.
  - At t+1: bus shows beat0 = instr[11:0], tag 01, beat 0.
- I0 -> I1: registers beat1 = instr[23:12], beat 1.
- I1 -> I2: registers beat2 = {4'b0, instr[31:24]}, beat 2.
- I2 next-state:
  - need[0] -> W1.
  - else need[1] -> W2.
  - else IDLE, and frame complete.
  - The bus goes invalid in the next cycle.
- W1:
  - in1_ready = 1.
  - On transfer at cycle t: beat at t+1 with in1_data, tag 10, beat 0. Next state: need[1] ? W2 : IDLE.
  - A frame that ends here is complete.
- W2: same as W1 using in2_* and tag 11. Always goes to IDLE, frame complete.
- Only one ready signal is high at a time. in1_ready and in2_ready are never high outside W1 and W2.
- Wait and timeout:
  - In W1/W2, each cycle without a transfer increments stall_count, saturating at 0xFFFF, and increments the wait counter.
  - If TIMEOUT != 0 and the wait counter reaches TIMEOUT-1 without valid, the next cycle emits the beat with data 0 and the correct tag. timeout_err is set and the state advances as if transferred. The ready signal is dropped that cycle; no handshake is consumed.
  - The wait counter clears on leaving W1/W2.
  - valid arriving in the same cycle as the timeout wins: real data, no error.
- frame_count increments once per completed frame, on the cycle the state returns to IDLE, and wraps at 16 bits.
- Minimum frame period with no data beats: 4 cycles. Accept at t, beats at t+1..t+3, next accept at t+4 at the earliest.
- halt is sampled only in IDLE. Asserting it mid-frame has no effect until the return to IDLE.
- bus_data holds its last value when bus_valid = 0. Only bus_valid qualifies it.

Test Plan:
- instr=0xABCDE123, need=00, valid held one cycle from IDLE -> beats 0x123/0 (tag 01), 0xCDE/1, 0x0AB/2 on three consecutive cycles; frame_count=1; instr_ready high again on the 4th cycle.
- need=11; in1_data=0x111 valid immediately; in2_data=0x222 valid 3 cycles later -> instruction beats, then 10:0x111, then 3 idle cycles, then 11:0x222; stall_count=3; timeout_err=0.
- TIMEOUT=8, need=01, in1_valid never asserted -> 7 stall cycles, then tag-10 beat with data 0x000; timeout_err=1 and stays set; in1_ready never seen with valid.
- Back-to-back: instr_valid held with need=00 for 3 instructions -> accepts at t, t+4, t+8; frame_count=3; no overlapping beats.
- halt raised during I1 -> frame finishes; instr_ready stays 0 in IDLE until halt falls, then the next instruction is accepted that cycle.
- rst_n pulsed low during W1 -> all outputs 0 asynchronously; after release busy=0, counters 0, and no stale tag-10 beat appears.
